// File: rtl/sp_fifo_ctrl.sv
`timescale 1ns/1ps
// sp_fifo_ctrl
//   FIFO controller that shares a single external single-port RAM between a
//   push stream and a pop stream. The RAM performs one access per cycle: either
//   a write, or a read whose data appears on ram_rdata one cycle later. Read
//   data is held by the RAM on write cycles. A 2-entry output buffer (obuf)
//   hides the RAM read latency from the consumer.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_ready     push handshake, s_data is the pushed word
//   m_valid/m_ready     pop handshake, m_data is the obuf head
//   count               words held (RAM + read in flight + obuf), up to DEPTH+2
//   full                RAM holds DEPTH words
//   empty               count == 0
//   ram_wren            RAM write strobe (0 = read or idle)
//   ram_addr            RAM address
//   ram_wdata           RAM write data (s_data passed through)
//   ram_rdata           RAM registered read data
module sp_fifo_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 3)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             ram_wren,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata
);

  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      ram_cnt_q, ram_cnt_d;
  logic             rd_inflight_q, rd_inflight_d;
  logic [1:0]       obuf_cnt_q, obuf_cnt_d;
  logic [WIDTH-1:0] obuf0_q, obuf0_d;
  logic [WIDTH-1:0] obuf1_q, obuf1_d;
  logic             wr_pri_q, wr_pri_d;
  logic             ready_en_q, ready_en_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  logic wr_req;
  logic rd_want;
  logic wr_gnt;
  logic rd_gnt;
  logic obuf_push;
  logic obuf_pop;

  // Arbitration uses registered state only, so m_ready never reaches s_ready.
  // rd_want counts the in-flight read as an occupied obuf slot, which is what
  // guarantees the returning word always has room.
  always_comb begin
    wr_req   = s_valid && !full_q && ready_en_q;
    rd_want  = (ram_cnt_q != '0) &&
               (({1'b0, rd_inflight_q} + obuf_cnt_q) < 2'd2);
    wr_gnt   = wr_req && (wr_pri_q || !rd_want);
    rd_gnt   = rd_want && !wr_gnt;
    s_ready  = ready_en_q && !full_q && !(rd_want && !wr_pri_q);
    ram_wren = wr_gnt;
    ram_addr = wr_gnt ? wr_ptr_q : rd_ptr_q;
    ram_wdata = s_data;
  end

  // Pointer, occupancy and priority bookkeeping. A write and a read grant are
  // mutually exclusive, so ram_cnt moves by at most one per cycle.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    ram_cnt_d     = ram_cnt_q;
    wr_pri_d      = wr_pri_q;
    rd_inflight_d = rd_gnt;
    ready_en_d    = 1'b1;
    if (wr_gnt) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      ram_cnt_d = ram_cnt_q + (AW + 1)'(1);
      wr_pri_d  = 1'b0;
    end else if (rd_gnt) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      ram_cnt_d = ram_cnt_q - (AW + 1)'(1);
      wr_pri_d  = 1'b1;
    end
  end

  // Output buffer: obuf0 is the head. A push arrives the cycle after a read
  // grant; a simultaneous push and pop shifts the queue and refills the tail.
  always_comb begin
    obuf_push  = rd_inflight_q;
    obuf_pop   = (obuf_cnt_q != 2'd0) && m_ready;
    obuf0_d    = obuf0_q;
    obuf1_d    = obuf1_q;
    obuf_cnt_d = obuf_cnt_q;
    case ({obuf_push, obuf_pop})
      2'b10: begin
        if (obuf_cnt_q == 2'd0) obuf0_d = ram_rdata;
        else                    obuf1_d = ram_rdata;
        obuf_cnt_d = obuf_cnt_q + 2'd1;
      end
      2'b01: begin
        obuf0_d    = obuf1_q;
        obuf_cnt_d = obuf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (obuf_cnt_q == 2'd1) begin
          obuf0_d = ram_rdata;
        end else begin
          obuf0_d = obuf1_q;
          obuf1_d = ram_rdata;
        end
      end
      default: ;
    endcase
  end

  // Status flags are registered from the next-state values.
  always_comb begin
    count_d = CW'(ram_cnt_d) + CW'(rd_inflight_d) + CW'(obuf_cnt_d);
    full_d  = (ram_cnt_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ram_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      obuf_cnt_q    <= 2'd0;
      obuf0_q       <= '0;
      obuf1_q       <= '0;
      wr_pri_q      <= 1'b1;
      ready_en_q    <= 1'b0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ram_cnt_q     <= ram_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      obuf_cnt_q    <= obuf_cnt_d;
      obuf0_q       <= obuf0_d;
      obuf1_q       <= obuf1_d;
      wr_pri_q      <= wr_pri_d;
      ready_en_q    <= ready_en_d;
      count_q       <= count_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
    end
  end

  assign m_valid = (obuf_cnt_q != 2'd0);
  assign m_data  = obuf0_q;
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: tb/tb_sp_fifo_ctrl.sv
`timescale 1ns/1ps
// Testbench for sp_fifo_ctrl with a behavioural single-port RAM.
// Inputs change 1ns after the rising edge; everything is sampled on the
// falling edge. Accepted pushes go into exp_q; the monitor pops exp_q on
// every accepted pop and compares in order.
module tb_sp_fifo_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 128;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 3);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             ram_wren;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata = '0;

  logic [WIDTH-1:0] mem [DEPTH];

  int checks_total = 0;
  int checks_passed = 0;
  logic [WIDTH-1:0] exp_q[$];

  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  sp_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .full(full), .empty(empty),
    .ram_wren(ram_wren), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM: write, or registered read; read data held on write cycles.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    else          ram_rdata <= mem[ram_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // One cycle of stimulus; reports whether the push handshake will complete.
  task automatic applyStimulus(input logic sv, input logic [WIDTH-1:0] d,
                               input logic mr, output logic acc);
    @(posedge clk);
    #1;
    s_valid = sv;
    s_data  = d;
    m_ready = mr;
    @(negedge clk);
    acc = s_valid && s_ready;
    if (acc) exp_q.push_back(d);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drainAll(input string name, input int budget);
    logic acc;
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      applyStimulus(1'b0, '0, 1'b1, acc);
      cyc++;
    end
    checkOutput({name, "_left"}, exp_q.size(), 0);
    applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput({name, "_count"}, 32'(count), 0);
    checkOutput({name, "_empty"}, 32'(empty), 1);
    checkOutput({name, "_mvalid"}, 32'(m_valid), 0);
  endtask

  // Scoreboard monitor: in-order data check and hold-while-stalled check.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_hold_valid", 32'(m_valid), 1);
        checkOutput("stall_hold_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks_total++;
          $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", m_data);
        end else begin
          checkOutput("pop_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic acc;
    int   acc_cnt;
    int   cyc;
    int   lat;
    int   errs;
    logic prev_wren;
    logic sv;
    logic mr;

    // Reset release: ready_en comes up one cycle later.
    $display("[TB] reset state");
    doReset();
    checkOutput("rst_s_ready", 32'(s_ready), 0);
    checkOutput("rst_m_valid", 32'(m_valid), 0);
    checkOutput("rst_m_data", 32'(m_data), 0);
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_empty", 32'(empty), 1);
    checkOutput("rst_full", 32'(full), 0);
    checkOutput("rst_ram_wren", 32'(ram_wren), 0);
    applyStimulus(1'b0, '0, 1'b0, acc);
    checkOutput("rdy_after_1cyc", 32'(s_ready), 1);

    // Single-word latency: lat includes the acceptance edge, so 3 = N+2.
    $display("[TB] latency");
    applyStimulus(1'b1, 8'hA5, 1'b1, acc);
    checkOutput("t2_accept", 32'(acc), 1);
    lat = 0;
    while (lat < 10) begin
      applyStimulus(1'b0, '0, 1'b1, acc);
      lat++;
      if (m_valid) break;
    end
    checkOutput("t2_latency", lat, 3);
    checkOutput("t2_m_data", 32'(m_data), 32'h0000_00A5);
    checkOutput("t2_count_held", 32'(count), 1);
    applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("t2_count_after", 32'(count), 0);
    checkOutput("t2_empty_after", 32'(empty), 1);

    // Fill to capacity with the consumer stalled: DEPTH in RAM + 2 in obuf.
    $display("[TB] fill to capacity");
    doReset();
    acc_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 8'(acc_cnt), 1'b0, acc);
      if (acc) acc_cnt++;
    end
    checkOutput("t3_accepted", acc_cnt, DEPTH + 2);
    checkOutput("t3_full", 32'(full), 1);
    checkOutput("t3_s_ready", 32'(s_ready), 0);
    checkOutput("t3_count", 32'(count), DEPTH + 2);
    checkOutput("t3_head", 32'(m_data), 0);
    drainAll("t3_drain", 400);

    // Continuous push and pop: RAM port alternates write/read every cycle.
    $display("[TB] contention");
    acc_cnt = 0;
    cyc = 0;
    errs = 0;
    prev_wren = 1'b0;
    while (acc_cnt < 1000 && cyc < 2500) begin
      applyStimulus(1'b1, 8'(acc_cnt) ^ 8'h5A, 1'b1, acc);
      if (cyc != 0 && ram_wren == prev_wren) errs++;
      prev_wren = ram_wren;
      if (acc) acc_cnt++;
      cyc++;
    end
    checkOutput("t4_words", acc_cnt, 1000);
    checkOutput("t4_wren_alt_errors", errs, 0);
    drainAll("t4_drain", 50);

    // Random stalls across several pointer wraps.
    $display("[TB] random stalls");
    acc_cnt = 0;
    cyc = 0;
    while (acc_cnt < 3 * DEPTH && cyc < 5000) begin
      sv = ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 2) != 0);
      applyStimulus(sv, 8'(acc_cnt * 7 + 3), mr, acc);
      if (acc) acc_cnt++;
      cyc++;
    end
    checkOutput("t5_words", acc_cnt, 3 * DEPTH);
    drainAll("t5_drain", 500);

    // Reset mid-operation: everything in flight is dropped.
    $display("[TB] reset mid-operation");
    acc_cnt = 0;
    cyc = 0;
    while (acc_cnt < 50 && cyc < 200) begin
      applyStimulus(1'b1, 8'(acc_cnt + 8'h80), 1'b0, acc);
      if (acc) acc_cnt++;
      cyc++;
    end
    applyStimulus(1'b0, '0, 1'b0, acc);
    applyStimulus(1'b0, '0, 1'b0, acc);
    checkOutput("t6_count_before", 32'(count), 50);
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("t6_async_count", 32'(count), 0);
    checkOutput("t6_async_m_valid", 32'(m_valid), 0);
    checkOutput("t6_async_empty", 32'(empty), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("t6_m_valid_after", 32'(m_valid), 0);
    cyc = 0;
    acc = 1'b0;
    while (!acc && cyc < 10) begin
      applyStimulus(1'b1, 8'h11, 1'b1, acc);
      cyc++;
    end
    cyc = 0;
    acc = 1'b0;
    while (!acc && cyc < 10) begin
      applyStimulus(1'b1, 8'h22, 1'b1, acc);
      cyc++;
    end
    checkOutput("t6_pushed", exp_q.size() + 0, 2);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("t6_left", exp_q.size(), 0);
    checkOutput("t6_count_end", 32'(count), 0);
    checkOutput("t6_empty_end", 32'(empty), 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
